// File: rtl/seqdet_pkg.sv
// Shared types and constants for the round-robin "1011" sequence detector.
package seqdet_pkg;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } seq_state_t;

  localparam int unsigned      CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

  // Saturating increment used by the optional per-channel match counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/seqdet_step.sv
// Combinational overlapping "1011" Mealy step, shared by every channel.
module seqdet_step
  import seqdet_pkg::*;
(
  input  seq_state_t state,
  input  logic       bit_in,
  output seq_state_t next_state,
  output logic       hit
);

  always_comb begin
    next_state = S0;
    hit        = 1'b0;
    unique case (state)
      S0: next_state = bit_in ? S1 : S0;
      S1: next_state = bit_in ? S1 : S2;
      S2: next_state = bit_in ? S3 : S0;
      S3: begin
        next_state = bit_in ? S1 : S2;
        hit        = bit_in;
      end
      default: next_state = S0;
    endcase
  end

endmodule

// File: rtl/seqdet_rr_sched.sv
// Round-robin scheduler sharing one "1011" detector step among NUM_CH serial channels.
// Optional per-channel saturating match counters when SEQDET_MATCH_CNT_EN is defined.
module seqdet_rr_sched
  import seqdet_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [NUM_CH-1:0] ch_valid,
  input  logic [NUM_CH-1:0] ch_bit,
  output logic [NUM_CH-1:0] ch_ready,
  output logic              match_valid,
  output logic [CH_W-1:0]   match_ch
`ifdef SEQDET_MATCH_CNT_EN
  ,
  input  logic [CH_W-1:0]   cnt_sel,
  output logic [CNT_W-1:0]  cnt_value
`endif
);

  seq_state_t        state_q [NUM_CH];
  seq_state_t        state_d [NUM_CH];
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   g;
  logic              grant_any;
  logic              xfer;
  seq_state_t        step_next;
  logic              step_hit;

  // First requester at or after rr_ptr, wrapping around.
  always_comb begin
    grant_any = 1'b0;
    g         = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      int unsigned idx;
      idx = 32'(rr_ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!grant_any && ch_valid[idx[CH_W-1:0]]) begin
        grant_any = 1'b1;
        g         = idx[CH_W-1:0];
      end
    end
  end

  // clear masks the grant so nothing transfers while the states flush.
  assign xfer = grant_any & ~clear;

  seqdet_step u_step (
    .state      (state_q[g]),
    .bit_in     (ch_bit[g]),
    .next_state (step_next),
    .hit        (step_hit)
  );

  // State register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) state_q[i] <= S0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) state_q[i] <= state_d[i];
    end
  end

  // Next-state: only the granted entry advances.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) state_d[i] = state_q[i];
    if (clear) begin
      for (int unsigned i = 0; i < NUM_CH; i++) state_d[i] = S0;
    end else if (xfer) begin
      state_d[g] = step_next;
    end
  end

  // Output: one-hot grant.
  always_comb begin
    ch_ready = '0;
    if (xfer) ch_ready[g] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr      <= '0;
      match_valid <= 1'b0;
      match_ch    <= '0;
    end else begin
      match_valid <= xfer & step_hit;
      if (xfer) begin
        rr_ptr <= (g == CH_W'(NUM_CH - 1)) ? '0 : g + 1'b1;
        if (step_hit) match_ch <= g;
      end
    end
  end

`ifdef SEQDET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q [NUM_CH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else if (clear) begin
      for (int unsigned i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else if (xfer && step_hit) begin
      cnt_q[g] <= sat_inc(cnt_q[g]);
    end
  end

  always_comb begin
    cnt_value = '0;
    if (32'(cnt_sel) < NUM_CH) cnt_value = cnt_q[cnt_sel];
  end
`endif

endmodule

// File: doc/seqdet_rr_sched.md
# seqdet_rr_sched

Round-robin scheduler that shares a single overlapping "1011" Mealy detection step among NUM_CH independent serial bit channels. Each channel's 2-bit detector state lives in a per-channel register file. One granted bit is advanced per clock, and matches are reported with the source channel index. The block sits between multiple serial front-ends and the event/interrupt logic.

## Interface
- NUM_CH, 4: number of serial requester channels (2..16).
- CH_W, $clog2(NUM_CH): width of the channel index.
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- clear  in  1  synchronous flush of all channel states to S0.
- ch_valid  in  NUM_CH  per-channel bit-available request.
- ch_bit  in  NUM_CH  per-channel serial data bit.
- ch_ready  out  NUM_CH  one-hot grant; combinational from ch_valid, pointer and clear.
- match_valid  out  1  registered one-cycle pulse: a "1011" completed.
- match_ch  out  CH_W  channel that matched; valid only with match_valid.
- cnt_sel  in  CH_W  counter read select (only with SEQDET_MATCH_CNT_EN).
- cnt_value  out  8  match count of channel cnt_sel (only with SEQDET_MATCH_CNT_EN).

## Operation
- Transfer on channel i: ch_valid[i] & ch_ready[i] in the same cycle.
- Arbitration:
  - Round-robin; search starts at rr_ptr. The first requesting channel at or after rr_ptr (wrapping) is granted.
  - After a transfer on channel g, rr_ptr <= (g+1) mod NUM_CH. With no transfer, rr_ptr holds.
  - At most one ch_ready bit is high. ch_ready is all zero when no channel requests or when clear=1.
- Per-channel detector state, shared step function (Mealy, overlapping):
  - S0 (none): 1->S1; 0->S0.
  - S1 ("1"): 1->S1; 0->S2.
  - S2 ("10"): 1->S3; 0->S0.
  - S3 ("101"): 1->S1 with match; 0->S2.
- Only the granted channel's state entry is updated. All other entries hold.
- On a match: match_valid <= 1 and match_ch <= g on the next edge. Otherwise match_valid <= 0. match_ch holds its last value.
- Reset values: all states S0, rr_ptr 0, match_valid 0, match_ch 0, counters 0.

## Timing
- Grant is decided in the same cycle as the request. The state update and match report take effect at the next rising edge (latency 1).
- A channel holding ch_valid continuously with no competitors gets one bit per cycle.
- With k active requesters, each gets one bit every k cycles. Worst-case wait is NUM_CH-1 cycles.
- Bits on one channel are never reordered or dropped. A channel's ch_bit must be held until its transfer.
- clear with pending requests:
  - Clear wins: no transfer, all states go to S0, and match_valid is 0 next cycle.
  - rr_ptr holds; counters are cleared.
- rst mid-stream: all state returns to reset values immediately. Partial matches are lost.
- A match completing on the same cycle clear rises is not reported, because clear blocks the transfer.

## Configuration
- SEQDET_MATCH_CNT_EN defined:
  - Adds one 8-bit match counter per channel. The counter increments on each reported match of that channel and saturates at 255.
  - Counters are zeroed by rst and clear.
  - Adds ports cnt_sel and cnt_value. cnt_value is combinational: counter[cnt_sel]. A cnt_sel out of range reads 0.
- SEQDET_MATCH_CNT_EN undefined: no counters, no cnt_sel/cnt_value ports, and all other behaviour is identical.

## Structure
- Package seqdet_pkg:
  - State typedef with encodings S0=2'b00, S1=2'b01, S2=2'b10, S3=2'b11.
  - Counter width constant 8 and its saturation value 255.
- Sub-module seqdet_step: purely combinational; inputs state and bit, outputs next_state and hit. It is instantiated once and shared by all channels.
- Arbiter, state register file, rr_ptr and output registers live in seqdet_rr_sched.

## Test plan
- Single channel 0, bits 1,0,1,1 on consecutive cycles:
  - match_valid pulses exactly once, one cycle after the fourth bit, with match_ch=0.
- Overlap, channel 1, bits 1,0,1,1,0,1,1:
  - Two matches, after bits 4 and 7, both with match_ch=1.
- All 4 channels request continuously:
  - Grants rotate 0,1,2,3,0.
  - Channel 2 fed 1,0,1,1 matches on its 4th grant (cycle 15 after start); other channels fed zeros never match.
- Clear and reset:
  - Channel 3 reaches S3 (1,0,1), then clear=1 for one cycle, then bit 1: no match.
  - Repeat with rst pulsed mid-stream instead of clear: same result, and rr_ptr returns to 0.
- With SEQDET_MATCH_CNT_EN, channel 0 fed "1011" repeated 300 times: cnt_sel=0 reads 255, and cnt_sel=1 reads 0.
- Idle input, no ch_valid for 20 cycles: ch_ready stays 0, match_valid stays 0, rr_ptr is unchanged.
